mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter BUS_TIMEOUT, default 16: maximum BUSY cycles to wait for i_bus_ack before a timeout fault; legal range 2..255.
REQ-002 i_clock  in  1  single clock; all state updates on the rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_isValid  in  1  the EX/MEM slot holds a valid operation.
REQ-005 i_addr  in  32  byte address (EX/MEM result data).
REQ-006 i_wrData  in  32  store data (EX/MEM B data).
REQ-007 i_memWrEnable / i_memRdEnable  in  1 each  store / load request.
REQ-008 i_memAccess  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-009 i_memUnsigned  in  1  zero-extend load data when 1, sign-extend when 0.
REQ-010 o_stall  out  1  holds the EX/MEM register; combinational.
REQ-011 o_rdData  out  32  extended load result; o_rdValid  out  1  one-cycle load-complete strobe.
REQ-012 o_fault  out  1  one-cycle fault strobe; o_faultCode  out  2  0 load misaligned, 1 store misaligned, 2 bus timeout, 3 illegal size.
REQ-013 Bus ports: o_bus_req out 1, o_bus_wr out 1, o_bus_addr out 32 (word aligned, bits[1:0]=0), o_bus_be out 4, o_bus_wrData out 32, i_bus_ack in 1, i_bus_rdData in 32.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE and FAULT.
REQ-015 An access is accepted in IDLE when i_isValid=1 and (i_memRdEnable or i_memWrEnable); when both enables are 1, the write SHALL take priority.
REQ-016 In IDLE, o_stall SHALL equal the accept condition; DONE and FAULT SHALL drive o_stall=0; BUSY SHALL drive o_stall=1.
REQ-017 Accept with size 3 -> FAULT, code 3; half with addr[0]=1, or word with addr[1:0]!=0 -> FAULT, code 0 (load) or 1 (store); no bus request is issued in either case.
REQ-018 Accept of an aligned access -> BUSY: the unit registers bus addr {addr[31:2],2'b00}, o_bus_wr, byte enables, write data and load extraction controls, then asserts o_bus_req.
REQ-019 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-020 Write data lanes: byte replicated x4, half replicated x2, word unchanged.
REQ-021 o_bus_req, o_bus_wr, o_bus_addr, o_bus_be and o_bus_wrData SHALL stay constant for every BUSY cycle.
REQ-022 In BUSY with i_bus_ack=1, the unit SHALL drop o_bus_req on the next edge and go to DONE; a load also registers i_bus_rdData shifted right by addr[1:0]*8 and extended to 32 bits per size and i_memUnsigned.
REQ-023 DONE SHALL pulse o_rdValid=1 for loads only (0 for stores), hold o_rdData until the next load completes, and return to IDLE unconditionally without re-accepting the current inputs.
REQ-024 A BUSY cycle counter SHALL reset on entry; if BUSY_TIMEOUT-1 is reached with i_bus_ack=0, the unit drops o_bus_req and goes to FAULT with code 2.
REQ-025 FAULT SHALL pulse o_fault=1 with o_faultCode, then return to IDLE unconditionally.
REQ-026 i_bus_ack outside BUSY SHALL be ignored.
REQ-027 Minimum latency SHALL be accept cycle N -> ack in N+1 -> DONE in N+2, i.e. o_stall high for 2 cycles.

Reset
REQ-028 i_reset=1 SHALL immediately force IDLE, o_bus_req=0, o_bus_wr=0, o_bus_addr=0, o_bus_be=0, o_bus_wrData=0, o_rdData=0, o_rdValid=0, o_fault=0, o_faultCode=0, counter=0.
REQ-029 Reset asserted during BUSY SHALL abort the transfer with no o_rdValid and no o_fault; after release the unit SHALL behave as if it had just been reset.

Verification
REQ-030 Load byte signed, addr 0x1003, bus data 0x80112233, ack in first BUSY cycle -> be 4'b1000, bus addr 0x1000, o_stall 1,1,0, o_rdValid in cycle N+2 with o_rdData 0xFFFFFF80; unsigned variant gives 0x00000080.
REQ-031 Store half, addr 0x2002, data 0x0000BEEF, ack after 3 BUSY cycles -> be 4'b1100, wrData 0xBEEFBEEF, bus signals stable through BUSY, no o_rdValid.
REQ-032 Load word at addr 0x3001 -> no o_bus_req, o_fault pulse with code 0; store word at 0x3002 -> code 1; size 3 -> code 3.
REQ-033 With BUSY_TIMEOUT=16 and ack never asserted -> o_bus_req high exactly 16 cycles, then o_fault with code 2 and o_stall=0.
REQ-034 Reset asserted in the second BUSY cycle -> o_bus_req falls before the next edge, then a following load at 0x0 with ack completes normally.
REQ-035 Back-to-back load then store, plus a stray ack in IDLE -> each access is performed exactly once and the stray ack has no effect.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM slot and a simple req/ack word bus.
// Checks alignment and size, drives byte lanes, extends load data, and times out a stalled bus.
module mem_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_isValid,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wrData,
  input  logic        i_memWrEnable,
  input  logic        i_memRdEnable,
  input  logic [1:0]  i_memAccess,
  input  logic        i_memUnsigned,
  output logic        o_stall,
  output logic [31:0] o_rdData,
  output logic        o_rdValid,
  output logic        o_fault,
  output logic [1:0]  o_faultCode,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wrData,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdData
);

  // state | meaning
  // IDLE  | waiting for a valid load/store
  // BUSY  | bus request outstanding, timeout counter running
  // DONE  | access finished; rdValid strobe for loads
  // FAULT | one-cycle fault strobe with faultCode
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FAULT} state_t;

  localparam logic [7:0] TMO_LOAD = 8'(BUS_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        accept;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wr_lanes;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    accept     = i_isValid & (i_memRdEnable | i_memWrEnable);
    misaligned = ((i_memAccess == 2'd1) & i_addr[0]) |
                 ((i_memAccess == 2'd2) & (i_addr[1:0] != 2'b00));
    be_new     = 4'b1111;
    wr_lanes   = i_wrData;
    case (i_memAccess)
      2'd0: begin
        be_new   = 4'b0001 << i_addr[1:0];
        wr_lanes = {4{i_wrData[7:0]}};
      end
      2'd1: begin
        be_new   = 4'b0011 << {i_addr[1], 1'b0};
        wr_lanes = {2{i_wrData[15:0]}};
      end
      default: ;
    endcase

    shifted  = i_bus_rdData >> {addr_lo_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = unsigned_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_wr_d      = bus_wr_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wr_data_d = bus_wr_data_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    addr_lo_d     = addr_lo_q;
    rd_data_d     = rd_data_q;
    fault_code_d  = fault_code_q;
    cnt_d         = cnt_q;
    o_stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_stall = accept;
        if (accept) begin
          if (i_memAccess == 2'd3) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd3;
          end else if (misaligned) begin
            state_d      = S_FAULT;
            fault_code_d = {1'b0, i_memWrEnable};
          end else begin
            // write wins when both enables are set
            state_d       = S_BUSY;
            bus_req_d     = 1'b1;
            bus_wr_d      = i_memWrEnable;
            bus_addr_d    = {i_addr[31:2], 2'b00};
            bus_be_d      = be_new;
            bus_wr_data_d = wr_lanes;
            size_d        = i_memAccess;
            unsigned_d    = i_memUnsigned;
            addr_lo_d     = i_addr[1:0];
            cnt_d         = TMO_LOAD;
          end
        end
      end
      S_BUSY: begin
        o_stall = 1'b1;
        if (i_bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          if (!bus_wr_q) rd_data_d = load_ext;
        end else if (cnt_q == 8'd0) begin
          state_d      = S_FAULT;
          bus_req_d    = 1'b0;
          fault_code_d = 2'd2;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      bus_req_q     <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wr_data_q <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      addr_lo_q     <= '0;
      rd_data_q     <= '0;
      fault_code_q  <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_wr_q      <= bus_wr_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wr_data_q <= bus_wr_data_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      addr_lo_q     <= addr_lo_d;
      rd_data_q     <= rd_data_d;
      fault_code_q  <= fault_code_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_bus_req    = bus_req_q;
  assign o_bus_wr     = bus_wr_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_be     = bus_be_q;
  assign o_bus_wrData = bus_wr_data_q;
  assign o_rdData     = rd_data_q;
  // DONE is only reachable from BUSY, so bus_wr_q still describes that access
  assign o_rdValid    = (state_q == S_DONE) & ~bus_wr_q;
  assign o_fault      = (state_q == S_FAULT);
  assign o_faultCode  = fault_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: alignment faults, lane steering, extension,
// timeout, reset abort and back-to-back traffic with a stray ack.
module tb_mem_access_unit;
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_isValid;
  logic [31:0] i_addr;
  logic [31:0] i_wrData;
  logic        i_memWrEnable;
  logic        i_memRdEnable;
  logic [1:0]  i_memAccess;
  logic        i_memUnsigned;
  logic        o_stall;
  logic [31:0] o_rdData;
  logic        o_rdValid;
  logic        o_fault;
  logic [1:0]  o_faultCode;
  logic        o_bus_req;
  logic        o_bus_wr;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wrData;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdData;

  int n_cmp = 0;
  int n_err = 0;
  int k;

  mem_access_unit #(.BUS_TIMEOUT(16)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_isValid(i_isValid), .i_addr(i_addr),
    .i_wrData(i_wrData), .i_memWrEnable(i_memWrEnable), .i_memRdEnable(i_memRdEnable),
    .i_memAccess(i_memAccess), .i_memUnsigned(i_memUnsigned), .o_stall(o_stall),
    .o_rdData(o_rdData), .o_rdValid(o_rdValid), .o_fault(o_fault), .o_faultCode(o_faultCode),
    .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
    .o_bus_wrData(o_bus_wrData), .i_bus_ack(i_bus_ack), .i_bus_rdData(i_bus_rdData)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clock);
  endtask

  task automatic op(input logic wr, input logic rd, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] sz, input logic uns);
    i_isValid = 1'b1; i_memWrEnable = wr; i_memRdEnable = rd;
    i_addr = a; i_wrData = d; i_memAccess = sz; i_memUnsigned = uns;
  endtask

  initial begin
    i_reset = 1'b1; i_isValid = 1'b0; i_addr = '0; i_wrData = '0;
    i_memWrEnable = 1'b0; i_memRdEnable = 1'b0; i_memAccess = 2'd0;
    i_memUnsigned = 1'b0; i_bus_ack = 1'b0; i_bus_rdData = '0;

    // reset state
    cyc();
    chk1("rst_req", o_bus_req, 1'b0);
    chk1("rst_wr", o_bus_wr, 1'b0);
    chk("rst_addr", o_bus_addr, 32'h0);
    chk("rst_be", {28'b0, o_bus_be}, 32'h0);
    chk("rst_wrdata", o_bus_wrData, 32'h0);
    chk("rst_rddata", o_rdData, 32'h0);
    chk1("rst_rdvalid", o_rdValid, 1'b0);
    chk1("rst_fault", o_fault, 1'b0);
    chk("rst_code", {30'b0, o_faultCode}, 32'h0);
    chk1("rst_stall", o_stall, 1'b0);
    i_reset = 1'b0;

    // load byte signed @0x1003, ack in first BUSY cycle
    cyc();
    op(1'b0, 1'b1, 32'h1003, 32'h0, 2'd0, 1'b0);
    #1 chk1("lb_stall_n", o_stall, 1'b1);
    chk1("lb_req_n", o_bus_req, 1'b0);
    cyc();
    chk1("lb_stall_n1", o_stall, 1'b1);
    chk1("lb_req_n1", o_bus_req, 1'b1);
    chk("lb_addr", o_bus_addr, 32'h1000);
    chk("lb_be", {28'b0, o_bus_be}, 32'h8);
    chk1("lb_wr", o_bus_wr, 1'b0);
    i_bus_ack = 1'b1; i_bus_rdData = 32'h80112233;
    cyc();
    i_bus_ack = 1'b0;
    chk1("lb_stall_n2", o_stall, 1'b0);
    chk1("lb_rdvalid", o_rdValid, 1'b1);
    chk("lb_rddata", o_rdData, 32'hFFFFFF80);
    chk1("lb_req_n2", o_bus_req, 1'b0);
    cyc();
    chk1("lb_no_reaccept", o_bus_req, 1'b0);
    chk1("lb_rdvalid_off", o_rdValid, 1'b0);
    i_isValid = 1'b0;

    // same load, unsigned
    cyc();
    op(1'b0, 1'b1, 32'h1003, 32'h0, 2'd0, 1'b1);
    cyc();
    i_bus_ack = 1'b1;
    cyc();
    i_bus_ack = 1'b0; i_isValid = 1'b0;
    chk1("lbu_rdvalid", o_rdValid, 1'b1);
    chk("lbu_rddata", o_rdData, 32'h00000080);

    // store half @0x2002, ack in fourth BUSY cycle
    cyc();
    op(1'b1, 1'b0, 32'h2002, 32'h0000BEEF, 2'd1, 1'b0);
    #1 chk1("sh_stall_n", o_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("sh_req", o_bus_req, 1'b1);
      chk1("sh_wr", o_bus_wr, 1'b1);
      chk("sh_addr", o_bus_addr, 32'h2000);
      chk("sh_be", {28'b0, o_bus_be}, 32'hC);
      chk("sh_wrdata", o_bus_wrData, 32'hBEEFBEEF);
      chk1("sh_stall", o_stall, 1'b1);
    end
    cyc();
    chk1("sh_req4", o_bus_req, 1'b1);
    chk("sh_wrdata4", o_bus_wrData, 32'hBEEFBEEF);
    i_bus_ack = 1'b1;
    cyc();
    i_bus_ack = 1'b0;
    chk1("sh_rdvalid", o_rdValid, 1'b0);
    chk1("sh_stall_done", o_stall, 1'b0);
    chk1("sh_req_done", o_bus_req, 1'b0);
    chk("sh_rddata_hold", o_rdData, 32'h00000080);
    i_isValid = 1'b0;

    // misaligned and illegal-size faults
    cyc();
    op(1'b0, 1'b1, 32'h3001, 32'h0, 2'd2, 1'b0);
    #1 chk1("lw_mis_stall", o_stall, 1'b1);
    cyc();
    chk1("lw_mis_fault", o_fault, 1'b1);
    chk("lw_mis_code", {30'b0, o_faultCode}, 32'd0);
    chk1("lw_mis_req", o_bus_req, 1'b0);
    chk1("lw_mis_stall_f", o_stall, 1'b0);
    i_isValid = 1'b0;
    cyc();
    chk1("lw_mis_fault_off", o_fault, 1'b0);
    op(1'b1, 1'b0, 32'h3002, 32'h12345678, 2'd2, 1'b0);
    cyc();
    chk1("sw_mis_fault", o_fault, 1'b1);
    chk("sw_mis_code", {30'b0, o_faultCode}, 32'd1);
    chk1("sw_mis_req", o_bus_req, 1'b0);
    i_isValid = 1'b0;
    cyc();
    op(1'b0, 1'b1, 32'h0, 32'h0, 2'd3, 1'b0);
    cyc();
    chk1("sz3_fault", o_fault, 1'b1);
    chk("sz3_code", {30'b0, o_faultCode}, 32'd3);
    chk1("sz3_req", o_bus_req, 1'b0);
    i_isValid = 1'b0;

    // bus timeout: req high exactly 16 cycles
    cyc();
    op(1'b0, 1'b1, 32'h4000, 32'h0, 2'd2, 1'b0);
    cyc();
    k = 0;
    while (o_bus_req && k < 40) begin
      k++;
      cyc();
    end
    chk("tmo_req_cycles", k, 32'd16);
    chk1("tmo_fault", o_fault, 1'b1);
    chk("tmo_code", {30'b0, o_faultCode}, 32'd2);
    chk1("tmo_stall", o_stall, 1'b0);
    i_isValid = 1'b0;

    // reset in the second BUSY cycle
    cyc();
    op(1'b0, 1'b1, 32'h5000, 32'h0, 2'd2, 1'b0);
    cyc();
    chk1("rb_req1", o_bus_req, 1'b1);
    cyc();
    chk1("rb_req2", o_bus_req, 1'b1);
    i_reset = 1'b1;
    #1 chk1("rb_req_drop", o_bus_req, 1'b0);
    chk("rb_addr", o_bus_addr, 32'h0);
    chk("rb_rddata", o_rdData, 32'h0);
    i_isValid = 1'b0;
    cyc();
    chk1("rb_rdvalid", o_rdValid, 1'b0);
    chk1("rb_fault", o_fault, 1'b0);
    i_reset = 1'b0;
    cyc();
    chk1("rb_fault_after", o_fault, 1'b0);
    op(1'b0, 1'b1, 32'h0, 32'h0, 2'd2, 1'b0);
    cyc();
    chk1("rb_ld_req", o_bus_req, 1'b1);
    chk("rb_ld_be", {28'b0, o_bus_be}, 32'hF);
    i_bus_ack = 1'b1; i_bus_rdData = 32'hCAFEF00D;
    cyc();
    i_bus_ack = 1'b0; i_isValid = 1'b0;
    chk1("rb_ld_rdvalid", o_rdValid, 1'b1);
    chk("rb_ld_rddata", o_rdData, 32'hCAFEF00D);

    // back-to-back load half signed then store byte
    cyc();
    op(1'b0, 1'b1, 32'h6002, 32'h0, 2'd1, 1'b0);
    cyc();
    chk("bb_ld_be", {28'b0, o_bus_be}, 32'hC);
    i_bus_ack = 1'b1; i_bus_rdData = 32'h87654321;
    cyc();
    i_bus_ack = 1'b0;
    chk1("bb_ld_rdvalid", o_rdValid, 1'b1);
    chk("bb_ld_rddata", o_rdData, 32'hFFFF8765);
    op(1'b1, 1'b0, 32'h6001, 32'h000000A5, 2'd0, 1'b0);
    cyc();
    chk1("bb_st_idle_req", o_bus_req, 1'b0);
    chk1("bb_st_stall", o_stall, 1'b1);
    cyc();
    chk1("bb_st_req", o_bus_req, 1'b1);
    chk1("bb_st_wr", o_bus_wr, 1'b1);
    chk("bb_st_addr", o_bus_addr, 32'h6000);
    chk("bb_st_be", {28'b0, o_bus_be}, 32'h2);
    chk("bb_st_wrdata", o_bus_wrData, 32'hA5A5A5A5);
    i_bus_ack = 1'b1; i_bus_rdData = 32'h11111111;
    cyc();
    i_isValid = 1'b0;
    chk1("bb_st_rdvalid", o_rdValid, 1'b0);
    chk1("bb_st_req_done", o_bus_req, 1'b0);
    chk("bb_st_rddata_hold", o_rdData, 32'hFFFF8765);

    // stray ack held high while idle
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("stray_req", o_bus_req, 1'b0);
      chk1("stray_rdvalid", o_rdValid, 1'b0);
      chk1("stray_fault", o_fault, 1'b0);
      chk1("stray_stall", o_stall, 1'b0);
      chk("stray_rddata", o_rdData, 32'hFFFF8765);
    end
    i_bus_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
